// File: rtl/fft_peak_detector_if.sv
// Bin stream in, peak result and framing error pulses out of fft_peak_detector.
// master is the upstream/consumer side, slave is the detector.
interface fft_peak_detector_if #(
    parameter int DATA_W = 24,
    parameter int IDX_W  = 7
);
    logic [2*DATA_W-1:0] s_axis_data_tdata;
    logic                s_axis_data_tvalid;
    logic                s_axis_data_tready;
    logic                s_axis_data_tlast;
    logic [IDX_W-1:0]    peak_idx;
    logic [2*DATA_W-1:0] peak_pwr;
    logic                peak_valid;
    logic                peak_ready;
    logic                err_tlast_unexpected;
    logic                err_tlast_missing;

    modport master (
        output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, peak_ready,
        input  s_axis_data_tready, peak_idx, peak_pwr, peak_valid,
               err_tlast_unexpected, err_tlast_missing
    );

    modport slave (
        input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, peak_ready,
        output s_axis_data_tready, peak_idx, peak_pwr, peak_valid,
               err_tlast_unexpected, err_tlast_missing
    );
endinterface

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over FFT bins by squared magnitude, one frame in flight.
// Define PEAK_SKIP_DC_EN to exclude bin 0 from the search.
//
// state | meaning
// ACCUM | accepting bins, pipeline advances per accepted beat
// DRAIN | frame closed, flushing closing bin through S1/S2/max
// HOLD  | result presented, waiting for peak_ready
module fft_peak_detector #(
    parameter int DATA_W = 24,
    parameter int NFFT   = 128,
    parameter int IDX_W  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_peak_detector_if.slave  bus
);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t              state;
    logic                tready_r;
    logic [IDX_W-1:0]    cnt;

    logic                s1_valid, s1_close;
    logic [2*DATA_W-1:0] s1_re2, s1_im2;
    logic [IDX_W-1:0]    s1_idx;

    logic                s2_valid, s2_close;
    logic [2*DATA_W-1:0] s2_pwr;
    logic [IDX_W-1:0]    s2_idx;

    logic [2*DATA_W-1:0] max_pwr;
    logic [IDX_W-1:0]    max_idx;
    logic                max_done;

    logic [2*DATA_W-1:0] peak_pwr_r;
    logic [IDX_W-1:0]    peak_idx_r;
    logic                peak_valid_r;
    logic                err_unexp_r, err_miss_r;

    logic signed [DATA_W-1:0]   re, im;
    logic signed [2*DATA_W-1:0] re_ext, im_ext, re_sq, im_sq;
    logic accept, last_bin, close, adv;
    logic load;
    logic [2*DATA_W-1:0] load_pwr;

    assign re     = bus.s_axis_data_tdata[2*DATA_W-1:DATA_W];
    assign im     = bus.s_axis_data_tdata[DATA_W-1:0];
    assign re_ext = {{DATA_W{re[DATA_W-1]}}, re};
    assign im_ext = {{DATA_W{im[DATA_W-1]}}, im};
    // Squares are non-negative and below 2^(2*DATA_W-1), so the low half of the product is exact
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;

    assign accept   = bus.s_axis_data_tvalid && tready_r;
    assign last_bin = (cnt == IDX_W'(NFFT - 1));
    assign close    = accept && (bus.s_axis_data_tlast || last_bin);
    assign adv      = accept || (state == DRAIN);

    always_comb begin
        load     = 1'b0;
        load_pwr = s2_pwr;
`ifdef PEAK_SKIP_DC_EN
        // DC loads zero so a one-bin frame reports (0, 0)
        if (s2_idx == '0) begin
            load     = 1'b1;
            load_pwr = '0;
        end else if (s2_idx == IDX_W'(1) || s2_pwr > max_pwr) begin
            load = 1'b1;
        end
`else
        if (s2_idx == '0 || s2_pwr > max_pwr)
            load = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            tready_r     <= 1'b0;
            cnt          <= '0;
            s1_valid     <= 1'b0;
            s1_close     <= 1'b0;
            s1_re2       <= '0;
            s1_im2       <= '0;
            s1_idx       <= '0;
            s2_valid     <= 1'b0;
            s2_close     <= 1'b0;
            s2_pwr       <= '0;
            s2_idx       <= '0;
            max_pwr      <= '0;
            max_idx      <= '0;
            max_done     <= 1'b0;
            peak_pwr_r   <= '0;
            peak_idx_r   <= '0;
            peak_valid_r <= 1'b0;
            err_unexp_r  <= 1'b0;
            err_miss_r   <= 1'b0;
        end else begin
            err_unexp_r <= accept && bus.s_axis_data_tlast && !last_bin;
            err_miss_r  <= accept && !bus.s_axis_data_tlast && last_bin;

            if (accept)
                cnt <= close ? '0 : cnt + 1'b1;

            if (adv) begin
                s1_valid <= accept;
                s1_re2   <= re_sq;
                s1_im2   <= im_sq;
                s1_idx   <= cnt;
                s1_close <= close;
                s2_valid <= s1_valid;
                s2_pwr   <= s1_re2 + s1_im2;
                s2_idx   <= s1_idx;
                s2_close <= s1_close;
            end

            if (adv && s2_valid && load) begin
                max_pwr <= load_pwr;
                max_idx <= s2_idx;
            end
            max_done <= adv && s2_valid && s2_close;

            case (state)
                ACCUM: begin
                    if (close) begin
                        state    <= DRAIN;
                        tready_r <= 1'b0;
                    end else begin
                        tready_r <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (max_done) begin
                        state        <= HOLD;
                        peak_valid_r <= 1'b1;
                        peak_idx_r   <= max_idx;
                        peak_pwr_r   <= max_pwr;
                    end
                end
                HOLD: begin
                    if (bus.peak_ready) begin
                        state        <= ACCUM;
                        peak_valid_r <= 1'b0;
                        tready_r     <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.s_axis_data_tready   = tready_r;
    assign bus.peak_idx             = peak_idx_r;
    assign bus.peak_pwr             = peak_pwr_r;
    assign bus.peak_valid           = peak_valid_r;
    assign bus.err_tlast_unexpected = err_unexp_r;
    assign bus.err_tlast_missing    = err_miss_r;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector; expectations follow PEAK_SKIP_DC_EN when defined.
module tb_fft_peak_detector;
    localparam int DATA_W = 24;
    localparam int IDX_W  = 7;
    localparam int NFFT   = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_peak_detector_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ifc();

    fft_peak_detector #(.DATA_W(DATA_W), .NFFT(NFFT), .IDX_W(IDX_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DATA_W-1:0] bin_re [256];
    logic signed [DATA_W-1:0] bin_im [256];
    int acc_cyc [256];

    int unexp_cnt = 0, miss_cnt = 0, miss_cyc = 0;
    int valid_cycles = 0, valid_cyc = 0, hs_cnt = 0;
    logic prev_valid = 1'b0;
    logic [IDX_W-1:0]    res_idx [32];
    logic [2*DATA_W-1:0] res_pwr [32];

    // Passive monitor of pulses and result handshakes
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.err_tlast_unexpected) unexp_cnt++;
            if (ifc.err_tlast_missing) begin
                miss_cnt++;
                miss_cyc = cyc;
            end
            if (ifc.peak_valid) begin
                valid_cycles++;
                if (!prev_valid) valid_cyc = cyc;
                if (ifc.peak_ready && hs_cnt < 32) begin
                    res_idx[hs_cnt] = ifc.peak_idx;
                    res_pwr[hs_cnt] = ifc.peak_pwr;
                    hs_cnt++;
                end
            end
        end
        prev_valid = ifc.peak_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_bins();
        for (int i = 0; i < 256; i++) begin
            bin_re[i] = '0;
            bin_im[i] = '0;
        end
    endtask

    // Caller is at a falling edge; each beat is held until accepted.
    task automatic send(input int base, input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            ifc.s_axis_data_tdata  = {bin_re[base+i], bin_im[base+i]};
            ifc.s_axis_data_tvalid = 1'b1;
            ifc.s_axis_data_tlast  = (i == last_pos);
            while (!ifc.s_axis_data_tready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!ifc.s_axis_data_tready) begin
                checks++;
                failures++;
                $display("FAIL send_timeout beat=%0d tready=%b required=1", base + i, ifc.s_axis_data_tready);
            end
            @(posedge clk);
            @(negedge clk);
            acc_cyc[base+i] = cyc;
        end
        ifc.s_axis_data_tvalid = 1'b0;
        ifc.s_axis_data_tlast  = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int w;
        w = 0;
        while (hs_cnt < target && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (hs_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL result_timeout handshakes=%0d required=%0d", hs_cnt, target);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.s_axis_data_tdata  = '0;
        ifc.s_axis_data_tvalid = 1'b0;
        ifc.s_axis_data_tlast  = 1'b0;
        ifc.peak_ready         = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifc.s_axis_data_tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", ifc.s_axis_data_tready); end
        checks++; if (ifc.peak_valid !== 1'b0) begin failures++; $display("FAIL rst_peak_valid got=%b exp=0", ifc.peak_valid); end
        checks++; if (ifc.peak_idx !== 7'd0) begin failures++; $display("FAIL rst_peak_idx got=%0d exp=0", ifc.peak_idx); end
        checks++; if (ifc.peak_pwr !== 48'd0) begin failures++; $display("FAIL rst_peak_pwr got=%0d exp=0", ifc.peak_pwr); end
        checks++; if (ifc.err_tlast_unexpected !== 1'b0 || ifc.err_tlast_missing !== 1'b0) begin
            failures++; $display("FAIL rst_err got=%b%b exp=00", ifc.err_tlast_unexpected, ifc.err_tlast_missing);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ifc.s_axis_data_tready !== 1'b1) begin failures++; $display("FAIL rst_release_tready got=%b exp=1", ifc.s_axis_data_tready); end
    endtask

    task automatic test_single_tone();
        int h;
        clear_bins();
        bin_re[10] = 24'sd1000;
        bin_im[10] = -24'sd500;
        ifc.peak_ready = 1'b1;
        unexp_cnt = 0; miss_cnt = 0; valid_cycles = 0;
        h = hs_cnt;
        send(0, 128, 127);
        checks++; if (ifc.s_axis_data_tready !== 1'b0) begin failures++; $display("FAIL tone_tready_fall got=%b exp=0", ifc.s_axis_data_tready); end
        wait_hs(h + 1);
        repeat (3) @(negedge clk);
        checks++; if (res_idx[h] !== 7'd10) begin failures++; $display("FAIL tone_idx got=%0d exp=10", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd1250000) begin failures++; $display("FAIL tone_pwr got=%0d exp=1250000", res_pwr[h]); end
        checks++; if (valid_cyc - acc_cyc[127] != 3) begin failures++; $display("FAIL tone_latency got=%0d exp=3", valid_cyc - acc_cyc[127]); end
        checks++; if (valid_cycles != 1) begin failures++; $display("FAIL tone_valid_cycles got=%0d exp=1", valid_cycles); end
        checks++; if (unexp_cnt != 0 || miss_cnt != 0) begin failures++; $display("FAIL tone_err got=%0d/%0d exp=0/0", unexp_cnt, miss_cnt); end
    endtask

    task automatic test_tie();
        int h;
        clear_bins();
        bin_re[5]  = 24'sh800000;
        bin_re[20] = 24'sh800000;
        h = hs_cnt;
        send(0, 128, 127);
        wait_hs(h + 1);
        checks++; if (res_idx[h] !== 7'd5) begin failures++; $display("FAIL tie_idx got=%0d exp=5", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd70368744177664) begin failures++; $display("FAIL tie_pwr got=%0d exp=70368744177664", res_pwr[h]); end
    endtask

    task automatic test_backpressure();
        int w, bad;
        clear_bins();
        bin_re[3] = 24'sd200;
        bin_im[3] = 24'sd100;
        ifc.peak_ready = 1'b0;
        send(0, 128, 127);
        w = 0;
        while (!ifc.peak_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        ifc.s_axis_data_tdata  = {24'sd4000, 24'sd0};
        ifc.s_axis_data_tvalid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.peak_valid !== 1'b1 || ifc.peak_idx !== 7'd3 || ifc.peak_pwr !== 48'd50000
                || ifc.s_axis_data_tready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold_stable bad_cycles=%0d exp=0", bad); end
        checks++; if (ifc.peak_idx !== 7'd3) begin failures++; $display("FAIL bp_idx got=%0d exp=3", ifc.peak_idx); end
        checks++; if (ifc.peak_pwr !== 48'd50000) begin failures++; $display("FAIL bp_pwr got=%0d exp=50000", ifc.peak_pwr); end
        #1;
        ifc.s_axis_data_tvalid = 1'b0;
        ifc.peak_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifc.s_axis_data_tready !== 1'b1) begin failures++; $display("FAIL bp_tready_rise got=%b exp=1", ifc.s_axis_data_tready); end
        checks++; if (ifc.peak_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", ifc.peak_valid); end
    endtask

    task automatic test_tlast_errors();
        int h;
        clear_bins();
        bin_re[40] = 24'sd300;
        bin_re[10] = 24'sd100;
        unexp_cnt = 0; miss_cnt = 0;
        h = hs_cnt;
        send(0, 64, 63);
        wait_hs(h + 1);
        checks++; if (unexp_cnt != 1) begin failures++; $display("FAIL early_unexp_pulses got=%0d exp=1", unexp_cnt); end
        checks++; if (miss_cnt != 0) begin failures++; $display("FAIL early_miss_pulses got=%0d exp=0", miss_cnt); end
        checks++; if (res_idx[h] !== 7'd40) begin failures++; $display("FAIL early_idx got=%0d exp=40", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd90000) begin failures++; $display("FAIL early_pwr got=%0d exp=90000", res_pwr[h]); end

        clear_bins();
        bin_re[77]  = 24'sd500;
        bin_re[30]  = 24'sd499;
        bin_re[128] = 24'sd7;
        bin_re[129] = 24'sd3;
        bin_im[129] = 24'sd4;
        unexp_cnt = 0; miss_cnt = 0;
        h = hs_cnt;
        send(0, 130, -1);
        wait_hs(h + 1);
        checks++; if (miss_cnt != 1) begin failures++; $display("FAIL miss_pulses got=%0d exp=1", miss_cnt); end
        checks++; if (miss_cyc != acc_cyc[127]) begin failures++; $display("FAIL miss_timing got=%0d exp=%0d", miss_cyc, acc_cyc[127]); end
        checks++; if (res_idx[h] !== 7'd77) begin failures++; $display("FAIL miss_idx got=%0d exp=77", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd250000) begin failures++; $display("FAIL miss_pwr got=%0d exp=250000", res_pwr[h]); end
        send(130, 126, 125);
        wait_hs(h + 2);
`ifdef PEAK_SKIP_DC_EN
        checks++; if (res_idx[h+1] !== 7'd1) begin failures++; $display("FAIL carry_idx got=%0d exp=1", res_idx[h+1]); end
        checks++; if (res_pwr[h+1] !== 48'd25) begin failures++; $display("FAIL carry_pwr got=%0d exp=25", res_pwr[h+1]); end
`else
        checks++; if (res_idx[h+1] !== 7'd0) begin failures++; $display("FAIL carry_idx got=%0d exp=0", res_idx[h+1]); end
        checks++; if (res_pwr[h+1] !== 48'd49) begin failures++; $display("FAIL carry_pwr got=%0d exp=49", res_pwr[h+1]); end
`endif
        checks++; if (unexp_cnt != 0 || miss_cnt != 1) begin failures++; $display("FAIL carry_err got=%0d/%0d exp=0/1", unexp_cnt, miss_cnt); end
    endtask

    task automatic test_reset_midframe();
        int h;
        clear_bins();
        bin_re[20] = 24'sd5000;
        send(0, 51, -1);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ifc.s_axis_data_tready !== 1'b0 || ifc.peak_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got=%b%b exp=00", ifc.s_axis_data_tready, ifc.peak_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_bins();
        bin_re[7] = 24'sd60;
        bin_im[7] = 24'sd80;
        unexp_cnt = 0; miss_cnt = 0;
        h = hs_cnt;
        send(0, 128, 127);
        wait_hs(h + 1);
        checks++; if (res_idx[h] !== 7'd7) begin failures++; $display("FAIL midrst_idx got=%0d exp=7", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd10000) begin failures++; $display("FAIL midrst_pwr got=%0d exp=10000", res_pwr[h]); end
        checks++; if (unexp_cnt != 0 || miss_cnt != 0) begin failures++; $display("FAIL midrst_err got=%0d/%0d exp=0/0", unexp_cnt, miss_cnt); end
    endtask

    task automatic test_dc();
        int h;
        clear_bins();
        bin_re[0] = 24'sd30000;
        bin_re[9] = 24'sd100;
        h = hs_cnt;
        send(0, 128, 127);
        wait_hs(h + 1);
`ifdef PEAK_SKIP_DC_EN
        checks++; if (res_idx[h] !== 7'd9) begin failures++; $display("FAIL dc_idx got=%0d exp=9", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd10000) begin failures++; $display("FAIL dc_pwr got=%0d exp=10000", res_pwr[h]); end
`else
        checks++; if (res_idx[h] !== 7'd0) begin failures++; $display("FAIL dc_idx got=%0d exp=0", res_idx[h]); end
        checks++; if (res_pwr[h] !== 48'd900000000) begin failures++; $display("FAIL dc_pwr got=%0d exp=900000000", res_pwr[h]); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_tie();
        test_backpressure();
        test_tlast_errors();
        test_reset_midframe();
        test_dc();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Downstream consumer of the FFT wrapper's output stream. It takes one complex bin per beat (real in the upper half, imaginary in the lower half), computes the squared magnitude of each bin, and tracks the largest bin across one frame. At the end of the frame it presents the peak bin index and its power on a valid/ready result port. It is the first spectral-analysis stage after the FFT, for example locating the 10 kHz tone in a 128-point frame.

## Interface
Parameters:
- DATA_W, 24, width of each signed real/imag component.
- NFFT, 128, bins per frame.
- IDX_W, 7, bin index width (equal to clog2(NFFT)).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_axis_data_tdata  input  2*DATA_W  [2*DATA_W-1:DATA_W] signed re, [DATA_W-1:0] signed im.
- s_axis_data_tvalid  input  1  input beat valid.
- s_axis_data_tready  output  1  block can accept a beat.
- s_axis_data_tlast  input  1  last bin of frame.
- peak_idx  output  IDX_W  index of the maximum-power bin.
- peak_pwr  output  2*DATA_W  unsigned re²+im² of that bin.
- peak_valid  output  1  result valid; held until accepted.
- peak_ready  input  1  result consumer ready.
- err_tlast_unexpected  output  1  one-cycle pulse: tlast arrived before bin NFFT-1.
- err_tlast_missing  output  1  one-cycle pulse: bin NFFT-1 accepted without tlast.

## Operation
- A beat is accepted when s_axis_data_tvalid && s_axis_data_tready.
- The bin counter starts at 0, increments per accepted beat and resets to 0 at frame close.
- Pipeline:
  - S1 registers re*re, im*im (signed DATA_W x DATA_W, result taken unsigned), bin index and a close flag.
  - S2 computes pwr = sum, 2*DATA_W bits unsigned. Maximum 2^(2*DATA_W-1), so it never overflows.
- Running max:
  - The first bin of a frame (index 0) loads max unconditionally.
  - Later bins replace max only if pwr > max (strictly greater). On a tie, the lowest index wins.
- Frame close occurs on an accepted beat with tlast, or on the accepted beat with counter == NFFT-1, whichever comes first.
  - tlast with counter < NFFT-1: pulse err_tlast_unexpected; the result covers the bins received.
  - Counter == NFFT-1 without tlast: pulse err_tlast_missing; close the frame anyway. The next beat starts a new frame.
- FSM states:
  - ACCUM: s_axis_data_tready=1. On an accepted closing beat, go to DRAIN.
  - DRAIN: tready=0. After the closing bin leaves S2, go to HOLD with peak_valid=1.
  - HOLD: tready=0. peak_idx and peak_pwr stay stable. On peak_valid && peak_ready, go to ACCUM.
- Only one frame is in flight; the upstream FFT is stalled through its own tready.
- Reset (asynchronous, any time, including mid-frame):
  - All outputs return to 0: peak_idx, peak_pwr, peak_valid, both err pulses.
  - s_axis_data_tready returns to 0 while rst_n is low, and goes to 1 on the first clk edge after release.
  - Pipeline contents and the partial frame are discarded; the state returns to ACCUM with counter 0.

## Timing
- Result latency: closing beat accepted at edge E, then peak_valid = 1 after edge E+3.
- s_axis_data_tready falls after edge E, i.e. in the cycle after the closing beat.
- s_axis_data_tready rises the cycle after the peak handshake edge.
- Throughput: one bin per clock during ACCUM. Back-to-back frames are separated by at least 3 cycles plus the consumer's peak_ready delay.
- Error pulses are high for exactly the one cycle after the closing-beat edge.
- peak_ready may be held high permanently; the result is then valid for exactly one cycle.
- A gap in tvalid inside a frame does not affect the result; the pipeline advances only on accepted beats or in DRAIN.

## Configuration
- PEAK_SKIP_DC_EN:
  - Defined: bin 0 is excluded from the search. Bin 1 loads max unconditionally, and peak_idx is never 0 unless the frame has exactly one bin (then peak_idx=0, peak_pwr=0).
  - Undefined: all bins, including DC, are candidates.

## Test plan
- 128-bin frame, all zero except bin 10 = (re=1000, im=-500), tlast on bin 127, peak_ready=1 -> peak_idx=10, peak_pwr=1250000, peak_valid for 1 cycle 3 edges after tlast, no error pulses.
- Bins 5 and 20 both (re=-8388608, im=0), others 0 -> peak_idx=5, peak_pwr=2^46; tie resolved to the lower index.
- Frame with peak at bin 3, peak_ready held low 20 cycles -> result stable for 20 cycles, tready=0 throughout; upstream beats not accepted; tready=1 the cycle after the handshake.
- tlast on bin 63 with the peak at bin 40 -> err_tlast_unexpected pulse, peak_idx=40. Then a 130-beat stream with no tlast -> err_tlast_missing after beat 127; beats 128-129 start the next frame.
- rst_n low mid-frame at bin 50, then a clean frame with the peak at bin 7 -> peak_idx=7; no residue from the aborted frame.
- PEAK_SKIP_DC_EN defined, bin 0=(30000,0), bin 9=(100,0) -> peak_idx=9, peak_pwr=10000. Undefined -> peak_idx=0, peak_pwr=900000000.
